// File: rtl/pc_arbiter_pkg.sv
// Shared constants and helpers for the packet arbiter. PC_PACKET_WIDTH mirrors
// the packet width of the shared parameter header so the arbiter builds standalone.
package pc_arbiter_pkg;

  localparam int PC_PACKET_WIDTH = 32;
  localparam int PC_NUM_PORTS    = 4;

  // Channel index following i in the round-robin order, wrapping at n-1.
  function automatic int wrap_inc(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/pc_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or after start_i,
// wrapping to 0. found_o is low when nothing requests.
module pc_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic          found_o
);

  always_comb begin
    gnt_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(start_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_arbiter.sv
// Round-robin arbiter feeding the packet queue through one registered output stage.
// Define PC_ARBITER_FIXED_PRIO_EN for fixed priority (channel 0 highest, no pointer).
module pc_arbiter
  import pc_arbiter_pkg::*;
#(
  parameter int PACKET_WIDTH = PC_PACKET_WIDTH,
  parameter int NUM_PORTS    = PC_NUM_PORTS
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_PORTS-1:0]              RECEIVE_PC_VALID,
  output logic [NUM_PORTS-1:0]              RECEIVE_PC_READY,
  input  logic [NUM_PORTS*PACKET_WIDTH-1:0] RECEIVE_PC_DATA,
  output logic                              SEND_PC_VALID,
  input  logic                              SEND_PC_READY,
  output logic [PACKET_WIDTH-1:0]           SEND_PC_DATA
);

  localparam int PTR_WIDTH = $clog2(NUM_PORTS);

  logic                    out_valid_q, out_valid_d;
  logic [PACKET_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_PORTS-1:0]    gnt;
  logic                    found;
  logic                    can_accept;
  logic                    xfer;
  logic [PTR_WIDTH-1:0]    start;

`ifdef PC_ARBITER_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`endif

  pc_arbiter_rr_pick #(
    .N  (NUM_PORTS),
    .PW (PTR_WIDTH)
  ) u_pick (
    .req_i   (RECEIVE_PC_VALID),
    .start_i (start),
    .gnt_o   (gnt),
    .found_o (found)
  );

  // Handshake: a transfer happens on channel i when VALID[i] && READY[i] at the
  // rising edge; SEND_PC_DATA is held while SEND_PC_VALID && !SEND_PC_READY.
  assign can_accept       = !out_valid_q || SEND_PC_READY;
  assign xfer             = found && can_accept && !RST;
  assign RECEIVE_PC_READY = xfer ? gnt : '0;
  assign SEND_PC_VALID    = out_valid_q;
  assign SEND_PC_DATA     = out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifndef PC_ARBITER_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[i]) begin
          out_data_d = RECEIVE_PC_DATA[i*PACKET_WIDTH +: PACKET_WIDTH];
`ifndef PC_ARBITER_FIXED_PRIO_EN
          ptr_d      = PTR_WIDTH'(wrap_inc(i, NUM_PORTS));
`endif
        end
      end
    end else if (SEND_PC_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifndef PC_ARBITER_FIXED_PRIO_EN
  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

endmodule
